alien_bomb_draw: RTL and testbench
==================================

// Module: alien_bomb_draw
// PURPOSE
//  Downward counterpart of the player laser: one alien bomb that falls toward the player.
//  Per frame it reads the alien-alive RAM to spawn from a live alien, or erases and advances
//  an existing bomb. It streams erase/draw pixels to the frame-buffer writer and flags player hits.
//  Runs once per frame between frame_start and out_bomb_done, alongside the laser drawer.
// PARAMETERS
//  BOMB_WIDTH 3 : pixels wide; must be odd; centred on bomb x
//  BOMB_LENGTH 8 : pixels tall; bomb y is the top row
//  BOMB_SPEED 4 : rows moved per frame
//  SCREEN_HEIGHT 480 : visible rows; the last row is SCREEN_HEIGHT-1
//  ALIEN_COLS 8 : aliens per row, power of 2; alien idx = row*ALIEN_COLS + col
//  ALIEN_WIDTH 40 / ALIEN_HEIGHT 21 / ALIEN_GAP 21 : alien geometry; group x/y is alien 0 top-left
//  PLAYER_WIDTH 32 / PLAYER_HEIGHT 32 : player box; player x/y is the box centre
//  BACKGROUND_COLOR_NUM 0 / BOMB_COLOR_NUM 3 : palette indices
// PORTS
//  clock input 1 : system clock
//  global_reset_n input 1 : asynchronous, active-low reset
//  frame_start input 1 : 1-cycle pulse that starts this frame's update
//  drop_req input 1 : level, sampled in S_START; request a new bomb if none is alive
//  drop_alien input 5 : alien index to drop from
//  alien_alive_data_in input 1 : alien-alive RAM read data, 1-cycle latency
//  alien_group_x input 10 / alien_group_y input 9 : alien group top-left
//  player_x input 10 / player_y input 9 : player centre
//  out_which_alien output 5 : alien-alive RAM read address (read-only; never writes)
//  out_x output 10 / out_y output 9 / out_which_color output 4 : pixel to write
//  out_pixel_valid output 1 : pixel fields valid this cycle
//  out_bomb_done output 1 : high in S_DONE
//  out_bomb_alive output 1 : bomb exists
//  out_player_hit output 1 : 1-cycle pulse on collision
//  out_drop_ack output 1 : 1-cycle pulse on spawn
// BEHAVIOUR
//  Reset: state S_IDLE; bomb_alive=0; every output 0.
//  S_IDLE/S_DONE + frame_start -> S_START. frame_start is ignored in every other state.
//  S_START: bomb_alive -> S_ERASE. Else drop_req -> S_READ (out_which_alien=drop_alien). Else -> S_DONE.
//  S_READ -> S_WAIT. S_WAIT samples alien_alive_data_in.
//    If it is 0 -> S_DONE, with no ack.
//    If it is 1 -> spawn. col=idx%ALIEN_COLS, row=idx/ALIEN_COLS.
//    bx=grp_x+col*(AW+AG)+AW/2; by=grp_y+row*(AH+AG)+AH.
//    Set bomb_alive=1, pulse out_drop_ack, go to S_DRAW.
//  S_ERASE/S_DRAW: one pixel per cycle, x inner loop bx-W/2..bx+W/2, y outer loop by..by+LEN-1.
//    Erase uses BACKGROUND colour; draw uses BOMB colour. W*LEN cycles, out_pixel_valid high throughout.
//    Pixel outputs are registered. S_ERASE -> S_MOVE after its last pixel; S_DRAW -> S_DONE.
//  S_MOVE: by+=BOMB_SPEED, computed in 11 bits.
//    Offscreen if by+LEN-1 > SCREEN_HEIGHT-1: bomb_alive=0 -> S_DONE.
//    Else hit if boxes overlap: bomb [bx-W/2,bx+W/2]x[by,by+LEN-1] against
//    player [px-PW/2,px+PW/2-1]x[py-PH/2,py+PH/2-1]. On hit: out_player_hit pulse, bomb_alive=0 -> S_DONE.
//    Offscreen takes priority over hit. Otherwise -> S_DRAW.
//  Spawn does no hit/offscreen check; the first check happens after the first move.
//  Async reset mid-stream ends the pixel stream immediately. The partial bomb is left on screen (caller clears).
//  Frame cost with bomb alive: W*LEN erase cycles + 1 move cycle + W*LEN draw cycles + overhead, under 60 cycles at defaults.
// TESTING
//  1 Spawn: grp(100,50), drop_alien=10, alive=1.
//    -> read addr 10; drop_ack; 24 px colour 3, x 241..243, y 113..120; done.
//  2 Dead alien: same as 1 but alive=0.
//    -> no pixels, no ack, bomb_alive=0, done within 4 cycles.
//  3 Next frame after 1:
//    -> 24 px colour 0 at y 113..120, then 24 px colour 3 at y 117..124.
//  4 Offscreen: bomb at by=470.
//    -> erase 24 px, no draw, bomb_alive=0, no hit.
//  5 Hit: player(242,440).
//    -> by=416 advances to 420 (rows 420..427 overlap 424..455): hit pulse, erase only, bomb_alive=0.
//    -> by=400 advances to 404: no hit.
//  6 Reset pulled low mid-draw:
//    -> all outputs 0 asynchronously; next frame_start with drop_req=0 gives no pixels.

Source files
------------

// File: rtl/alien_bomb_draw.sv
// Alien bomb: spawns under a live alien, then erases, falls and redraws once per frame.
// Streams erase/draw pixels to the frame-buffer writer and flags collisions with the player.
//
// Ports:
//   clock, global_reset_n      : clock, async active-low reset
//   frame_start                : 1-cycle pulse starting this frame's update
//   drop_req, drop_alien       : request a new bomb from the given alien index
//   alien_alive_data_in        : alien-alive RAM read data (1-cycle latency)
//   alien_group_x/y            : alien group top-left (alien 0)
//   player_x/y                 : player box centre
//   out_which_alien            : alien-alive RAM read address
//   out_x/out_y/out_which_color: pixel to write, qualified by out_pixel_valid
//   out_bomb_done              : high while this frame's work is finished
//   out_bomb_alive             : a bomb currently exists
//   out_player_hit             : 1-cycle pulse on collision
//   out_drop_ack               : 1-cycle pulse when a bomb spawns
module alien_bomb_draw #(
    parameter int BOMB_WIDTH           = 3,
    parameter int BOMB_LENGTH          = 8,
    parameter int BOMB_SPEED           = 4,
    parameter int SCREEN_HEIGHT        = 480,
    parameter int ALIEN_COLS           = 8,
    parameter int ALIEN_WIDTH          = 40,
    parameter int ALIEN_HEIGHT         = 21,
    parameter int ALIEN_GAP            = 21,
    parameter int PLAYER_WIDTH         = 32,
    parameter int PLAYER_HEIGHT        = 32,
    parameter int BACKGROUND_COLOR_NUM = 0,
    parameter int BOMB_COLOR_NUM       = 3
) (
    input  logic       clock,
    input  logic       global_reset_n,
    input  logic       frame_start,
    input  logic       drop_req,
    input  logic [4:0] drop_alien,
    input  logic       alien_alive_data_in,
    input  logic [9:0] alien_group_x,
    input  logic [8:0] alien_group_y,
    input  logic [9:0] player_x,
    input  logic [8:0] player_y,
    output logic [4:0] out_which_alien,
    output logic [9:0] out_x,
    output logic [8:0] out_y,
    output logic [3:0] out_which_color,
    output logic       out_pixel_valid,
    output logic       out_bomb_done,
    output logic       out_bomb_alive,
    output logic       out_player_hit,
    output logic       out_drop_ack
);

    localparam int CB  = $clog2(ALIEN_COLS);
    localparam int XCW = $clog2(BOMB_WIDTH + 1);
    localparam int YCW = $clog2(BOMB_LENGTH + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_ERASE = 3'd4;
    localparam logic [2:0] S_MOVE  = 3'd5;
    localparam logic [2:0] S_DRAW  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    logic [2:0]     state;
    logic           bomb_alive;
    logic [9:0]     bx;
    logic [10:0]    by;
    logic [XCW-1:0] xi;
    logic [YCW-1:0] yi;

    logic [CB-1:0]  col;
    logic [4:0]     row;
    logic [9:0]     spawn_x;
    logic [10:0]    spawn_y;
    logic [9:0]     pix_x;
    logic [8:0]     pix_y;
    logic           x_last;
    logic           y_last;
    logic [10:0]    by_n;
    logic [11:0]    bot;
    logic           offscreen;
    logic           hit_x;
    logic           hit_y;

    // Spawn position: horizontally centred under the alien,
    // top row just below the alien's bottom edge.
    always_comb begin
        col     = out_which_alien[CB-1:0];
        row     = out_which_alien >> CB;
        spawn_x = alien_group_x
                + 10'(col) * 10'(ALIEN_WIDTH + ALIEN_GAP)
                + 10'(ALIEN_WIDTH / 2);
        spawn_y = 11'(alien_group_y)
                + 11'(row) * 11'(ALIEN_HEIGHT + ALIEN_GAP)
                + 11'(ALIEN_HEIGHT);
    end

    always_comb begin
        pix_x  = bx - 10'(BOMB_WIDTH / 2) + 10'(xi);
        pix_y  = by[8:0] + 9'(yi);
        x_last = (xi == XCW'(BOMB_WIDTH - 1));
        y_last = (yi == YCW'(BOMB_LENGTH - 1));
    end

    // Move and collision, in widened unsigned arithmetic. The
    // half-widths are moved to the other side of each compare so
    // nothing can go negative near the screen edges.
    always_comb begin
        by_n      = by + 11'(BOMB_SPEED);
        bot       = 12'(by_n) + 12'(BOMB_LENGTH - 1);
        offscreen = bot > 12'(SCREEN_HEIGHT - 1);
        hit_x     = (12'(bx) + 12'(BOMB_WIDTH / 2 + PLAYER_WIDTH / 2)
                     >= 12'(player_x))
                 && (12'(bx) <= 12'(player_x)
                     + 12'(PLAYER_WIDTH / 2 - 1 + BOMB_WIDTH / 2));
        hit_y     = (bot + 12'(PLAYER_HEIGHT / 2) >= 12'(player_y))
                 && (12'(by_n) <= 12'(player_y)
                     + 12'(PLAYER_HEIGHT / 2 - 1));
    end

    assign out_bomb_done  = (state == S_DONE);
    assign out_bomb_alive = bomb_alive;

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state           <= S_IDLE;
            bomb_alive      <= 1'b0;
            bx              <= '0;
            by              <= '0;
            xi              <= '0;
            yi              <= '0;
            out_which_alien <= '0;
            out_x           <= '0;
            out_y           <= '0;
            out_which_color <= '0;
            out_pixel_valid <= 1'b0;
            out_player_hit  <= 1'b0;
            out_drop_ack    <= 1'b0;
        end else begin
            out_pixel_valid <= 1'b0;
            out_player_hit  <= 1'b0;
            out_drop_ack    <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (frame_start) state <= S_START;
                end
                S_START: begin
                    xi <= '0;
                    yi <= '0;
                    if (bomb_alive) begin
                        state <= S_ERASE;
                    end else if (drop_req) begin
                        out_which_alien <= drop_alien;
                        state           <= S_READ;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_READ: state <= S_WAIT;
                S_WAIT: begin
                    if (alien_alive_data_in) begin
                        bx           <= spawn_x;
                        by           <= spawn_y;
                        bomb_alive   <= 1'b1;
                        out_drop_ack <= 1'b1;
                        xi           <= '0;
                        yi           <= '0;
                        state        <= S_DRAW;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_ERASE, S_DRAW: begin
                    out_x           <= pix_x;
                    out_y           <= pix_y;
                    out_pixel_valid <= 1'b1;
                    out_which_color <= (state == S_ERASE)
                                     ? 4'(BACKGROUND_COLOR_NUM)
                                     : 4'(BOMB_COLOR_NUM);
                    if (x_last) begin
                        xi <= '0;
                        yi <= yi + 1'b1;
                        if (y_last) begin
                            yi    <= '0;
                            state <= (state == S_ERASE) ? S_MOVE : S_DONE;
                        end
                    end else begin
                        xi <= xi + 1'b1;
                    end
                end
                S_MOVE: begin
                    by <= by_n;
                    xi <= '0;
                    yi <= '0;
                    if (offscreen) begin
                        bomb_alive <= 1'b0;
                        state      <= S_DONE;
                    end else if (hit_x && hit_y) begin
                        out_player_hit <= 1'b1;
                        bomb_alive     <= 1'b0;
                        state          <= S_DONE;
                    end else begin
                        state <= S_DRAW;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alien_bomb_draw.sv
// Directed bench for alien_bomb_draw: spawn, dead alien, fall,
// offscreen, player hit and asynchronous reset mid-stream.
module tb_alien_bomb_draw;

    logic       clock = 1'b0;
    logic       global_reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       drop_req = 1'b0;
    logic [4:0] drop_alien = '0;
    logic       alien_alive_data_in;
    logic [9:0] alien_group_x = 10'd100;
    logic [8:0] alien_group_y = 9'd50;
    logic [9:0] player_x = 10'd242;
    logic [8:0] player_y = 9'd440;
    logic [4:0] out_which_alien;
    logic [9:0] out_x;
    logic [8:0] out_y;
    logic [3:0] out_which_color;
    logic       out_pixel_valid;
    logic       out_bomb_done;
    logic       out_bomb_alive;
    logic       out_player_hit;
    logic       out_drop_ack;

    logic [31:0] alive_mask = '0;

    int tests = 0;
    int fails = 0;

    // per-frame observations
    int n_px, n_c0, n_c3, acks, hits, cycles, seq;
    int last0, first3;
    int x3min, x3max, y3min, y3max, y0min, y0max;
    int fx, fy;
    bit done_seen;

    alien_bomb_draw dut (
        .clock               (clock),
        .global_reset_n      (global_reset_n),
        .frame_start         (frame_start),
        .drop_req            (drop_req),
        .drop_alien          (drop_alien),
        .alien_alive_data_in (alien_alive_data_in),
        .alien_group_x       (alien_group_x),
        .alien_group_y       (alien_group_y),
        .player_x            (player_x),
        .player_y            (player_y),
        .out_which_alien     (out_which_alien),
        .out_x               (out_x),
        .out_y               (out_y),
        .out_which_color     (out_which_color),
        .out_pixel_valid     (out_pixel_valid),
        .out_bomb_done       (out_bomb_done),
        .out_bomb_alive      (out_bomb_alive),
        .out_player_hit      (out_player_hit),
        .out_drop_ack        (out_drop_ack)
    );

    always #5 clock = ~clock;

    // alien-alive RAM: registered read, one cycle of latency
    always @(posedge clock) alien_alive_data_in <= alive_mask[out_which_alien];

    task automatic do_reset();
        global_reset_n = 1'b0;
        frame_start = 1'b0;
        drop_req = 1'b0;
        repeat (2) @(posedge clock);
        #1 global_reset_n = 1'b1;
    endtask

    task automatic run_frame(input logic dr, input logic [4:0] idx);
        n_px = 0; n_c0 = 0; n_c3 = 0; acks = 0; hits = 0;
        cycles = 0; seq = 0; last0 = -1; first3 = -1;
        x3min = 9999; x3max = -1; y3min = 9999; y3max = -1;
        y0min = 9999; y0max = -1; fx = -1; fy = -1;
        done_seen = 0;
        drop_req = dr;
        drop_alien = idx;
        frame_start = 1'b1;
        @(posedge clock);
        #1 frame_start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clock);
            #1;
            cycles++;
            if (out_pixel_valid) begin
                if (n_px == 0) begin
                    fx = int'(out_x);
                    fy = int'(out_y);
                end
                n_px++;
                if (out_which_color == 4'd0) begin
                    n_c0++;
                    last0 = seq;
                    if (int'(out_y) < y0min) y0min = int'(out_y);
                    if (int'(out_y) > y0max) y0max = int'(out_y);
                end else if (out_which_color == 4'd3) begin
                    n_c3++;
                    if (first3 < 0) first3 = seq;
                    if (int'(out_x) < x3min) x3min = int'(out_x);
                    if (int'(out_x) > x3max) x3max = int'(out_x);
                    if (int'(out_y) < y3min) y3min = int'(out_y);
                    if (int'(out_y) > y3max) y3max = int'(out_y);
                end
                seq++;
            end
            if (out_drop_ack) acks++;
            if (out_player_hit) hits++;
            if (out_bomb_done) begin
                done_seen = 1;
                break;
            end
        end
        drop_req = 1'b0;
        tests++;
        if (done_seen !== 1'b1) begin
            fails++;
            $display("FAIL frame_done: not reached in 100 cycles");
        end
    endtask

    task automatic test_reset();
        global_reset_n = 1'b0;
        #12;
        tests++;
        if ({out_which_alien, out_x, out_y, out_which_color,
             out_pixel_valid, out_bomb_done, out_bomb_alive,
             out_player_hit, out_drop_ack} !== 34'd0) begin
            fails++;
            $display("FAIL reset_outputs: got nonzero, expected all 0");
        end
        do_reset();
    endtask

    task automatic test_spawn();
        do_reset();
        alien_group_x = 10'd100;
        alien_group_y = 9'd50;
        alive_mask = 32'h1 << 10;
        run_frame(1'b1, 5'd10);
        tests++;
        if (out_which_alien !== 5'd10) begin
            fails++;
            $display("FAIL spawn_addr: got %0d expected 10", out_which_alien);
        end
        tests++;
        if (acks !== 1) begin
            fails++;
            $display("FAIL spawn_ack: got %0d expected 1", acks);
        end
        tests++;
        if (n_c3 !== 24 || n_c0 !== 0) begin
            fails++;
            $display("FAIL spawn_pixels: got c3=%0d c0=%0d expected 24/0",
                     n_c3, n_c0);
        end
        tests++;
        if (x3min !== 241 || x3max !== 243 || y3min !== 113 || y3max !== 120) begin
            fails++;
            $display("FAIL spawn_box: got x %0d..%0d y %0d..%0d expected x 241..243 y 113..120",
                     x3min, x3max, y3min, y3max);
        end
        tests++;
        if (fx !== 241 || fy !== 113) begin
            fails++;
            $display("FAIL spawn_first: got (%0d,%0d) expected (241,113)", fx, fy);
        end
        tests++;
        if (out_bomb_alive !== 1'b1) begin
            fails++;
            $display("FAIL spawn_alive: got %0b expected 1", out_bomb_alive);
        end
    endtask

    task automatic test_next_frame();
        run_frame(1'b0, 5'd0);
        tests++;
        if (n_c0 !== 24 || y0min !== 113 || y0max !== 120) begin
            fails++;
            $display("FAIL next_erase: got n=%0d y %0d..%0d expected 24 y 113..120",
                     n_c0, y0min, y0max);
        end
        tests++;
        if (n_c3 !== 24 || y3min !== 117 || y3max !== 124) begin
            fails++;
            $display("FAIL next_draw: got n=%0d y %0d..%0d expected 24 y 117..124",
                     n_c3, y3min, y3max);
        end
        tests++;
        if (!(last0 >= 0 && first3 > last0)) begin
            fails++;
            $display("FAIL next_order: got last_erase=%0d first_draw=%0d expected erase first",
                     last0, first3);
        end
        tests++;
        if (acks !== 0 || hits !== 0 || out_bomb_alive !== 1'b1) begin
            fails++;
            $display("FAIL next_flags: got ack=%0d hit=%0d alive=%0b expected 0/0/1",
                     acks, hits, out_bomb_alive);
        end
    endtask

    task automatic test_dead_alien();
        do_reset();
        alien_group_x = 10'd100;
        alien_group_y = 9'd50;
        alive_mask = ~(32'h1 << 10);
        run_frame(1'b1, 5'd10);
        tests++;
        if (n_px !== 0 || acks !== 0 || out_bomb_alive !== 1'b0) begin
            fails++;
            $display("FAIL dead_alien: got px=%0d ack=%0d alive=%0b expected 0/0/0",
                     n_px, acks, out_bomb_alive);
        end
        tests++;
        if (cycles > 4) begin
            fails++;
            $display("FAIL dead_latency: got %0d cycles expected <= 4", cycles);
        end
    endtask

    task automatic test_offscreen();
        do_reset();
        alien_group_x = 10'd100;
        alien_group_y = 9'd449;
        player_x = 10'd242;
        player_y = 9'd470;
        alive_mask = 32'h1 << 2;
        run_frame(1'b1, 5'd2);
        tests++;
        if (n_c3 !== 24 || y3min !== 470 || y3max !== 477) begin
            fails++;
            $display("FAIL off_spawn: got n=%0d y %0d..%0d expected 24 y 470..477",
                     n_c3, y3min, y3max);
        end
        run_frame(1'b0, 5'd0);
        tests++;
        if (n_c0 !== 24 || n_c3 !== 0) begin
            fails++;
            $display("FAIL off_pixels: got c0=%0d c3=%0d expected 24/0", n_c0, n_c3);
        end
        tests++;
        if (out_bomb_alive !== 1'b0 || hits !== 0) begin
            fails++;
            $display("FAIL off_flags: got alive=%0b hit=%0d expected 0/0",
                     out_bomb_alive, hits);
        end
    endtask

    task automatic test_hit();
        do_reset();
        alien_group_x = 10'd100;
        alien_group_y = 9'd395;
        player_x = 10'd242;
        player_y = 9'd440;
        alive_mask = 32'h1 << 2;
        run_frame(1'b1, 5'd2);
        tests++;
        if (y3min !== 416) begin
            fails++;
            $display("FAIL hit_spawn_y: got %0d expected 416", y3min);
        end
        run_frame(1'b0, 5'd0);
        tests++;
        if (hits !== 1 || n_c0 !== 24 || n_c3 !== 0 || out_bomb_alive !== 1'b0) begin
            fails++;
            $display("FAIL hit_416: got hit=%0d c0=%0d c3=%0d alive=%0b expected 1/24/0/0",
                     hits, n_c0, n_c3, out_bomb_alive);
        end
        do_reset();
        alien_group_y = 9'd379;
        run_frame(1'b1, 5'd2);
        run_frame(1'b0, 5'd0);
        tests++;
        if (hits !== 0 || n_c3 !== 24 || y3min !== 404 || out_bomb_alive !== 1'b1) begin
            fails++;
            $display("FAIL miss_400: got hit=%0d c3=%0d y=%0d alive=%0b expected 0/24/404/1",
                     hits, n_c3, y3min, out_bomb_alive);
        end
    endtask

    task automatic test_reset_mid_draw();
        bit streaming;
        do_reset();
        alien_group_x = 10'd100;
        alien_group_y = 9'd50;
        player_y = 9'd440;
        alive_mask = 32'h1 << 10;
        drop_req = 1'b1;
        drop_alien = 5'd10;
        frame_start = 1'b1;
        @(posedge clock);
        #1 frame_start = 1'b0;
        streaming = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            if (out_pixel_valid) begin
                streaming = 1;
                break;
            end
        end
        drop_req = 1'b0;
        tests++;
        if (!streaming) begin
            fails++;
            $display("FAIL mid_stream: got no pixels in 20 cycles expected stream");
        end
        repeat (3) @(posedge clock);
        #2 global_reset_n = 1'b0;
        #1;
        tests++;
        if ({out_which_alien, out_x, out_y, out_which_color,
             out_pixel_valid, out_bomb_done, out_bomb_alive,
             out_player_hit, out_drop_ack} !== 34'd0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got nonzero, expected all 0");
        end
        @(posedge clock);
        #1 global_reset_n = 1'b1;
        run_frame(1'b0, 5'd0);
        tests++;
        if (n_px !== 0 || out_bomb_alive !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_frame: got px=%0d alive=%0b expected 0/0",
                     n_px, out_bomb_alive);
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_next_frame();
        test_dead_alien();
        test_offscreen();
        test_hit();
        test_reset_mid_draw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
